// File: rtl/systolic_pe_dual_bank.sv
// systolic_pe_dual_bank
//   Output-stationary systolic processing element with NUM_ACC ping-pong
//   accumulator banks. One bank can accumulate while another drains.
//   Weights flow down, activations flow right, and drained results shift left.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   wgt/wgt_valid                weight operand from the PE above
//   act/act_valid/acc_bank       activation operand and its target bank, from the left
//   wgt_out/wgt_valid_out        weight and valid registered to the PE below
//   act_out/act_valid_out        activation and valid registered to the PE on the right
//   acc_bank_out                 target bank registered to the PE on the right
//   drain_start/drain_bank       one-cycle request to drain a bank
//   drain_in/drain_in_valid      result stream from the right neighbour
//   drain_out/drain_out_valid    result stream to the left neighbour
//   drain_busy                   drain sequencer is not idle
//   sat_flag, conflict_flag      sticky status flags; clear_flags clears them
//
// Handshake: the drain stream is valid-only, with no back-pressure. A word
// is transferred on every clock edge where its valid is high. When valid is
// low, the data lines carry no meaning. Gaps in drain_in_valid pass through
// to drain_out_valid one cycle later.
module systolic_pe_dual_bank #(
  parameter int DATA_WIDTH_BITS = 16,
  parameter int INT_BITS        = 7,
  parameter int FRAC_BITS       = 8,
  parameter int ACC_WIDTH_BITS  = 40,
  parameter int NUM_ACC         = 2,
  parameter int DRAIN_PASS      = 3,
  parameter int SATURATE        = 1,
  localparam int BW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH_BITS-1:0] wgt,
  input  logic                       wgt_valid,
  input  logic [DATA_WIDTH_BITS-1:0] act,
  input  logic                       act_valid,
  input  logic [BW-1:0]              acc_bank,
  output logic [DATA_WIDTH_BITS-1:0] wgt_out,
  output logic                       wgt_valid_out,
  output logic [DATA_WIDTH_BITS-1:0] act_out,
  output logic                       act_valid_out,
  output logic [BW-1:0]              acc_bank_out,
  input  logic                       drain_start,
  input  logic [BW-1:0]              drain_bank,
  input  logic [DATA_WIDTH_BITS-1:0] drain_in,
  input  logic                       drain_in_valid,
  output logic [DATA_WIDTH_BITS-1:0] drain_out,
  output logic                       drain_out_valid,
  output logic                       drain_busy,
  output logic                       sat_flag,
  output logic                       conflict_flag,
  input  logic                       clear_flags
);

  localparam int DW = DATA_WIDTH_BITS;
  localparam int AW = ACC_WIDTH_BITS;
  localparam int PW = 2 * DATA_WIDTH_BITS;
  localparam int CW = (DRAIN_PASS > 0) ? $clog2(DRAIN_PASS + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [DW-1:0] RES_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] RES_MIN = {1'b1, {(DW-1){1'b0}}};
  // Half an output LSB. Adding it before the shift rounds half up.
  localparam logic signed [AW:0] RND = {{(AW-FRAC_BITS+1){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

  if (DATA_WIDTH_BITS != 1 + INT_BITS + FRAC_BITS) begin : g_bad_format
    $error("DATA_WIDTH_BITS must equal 1+INT_BITS+FRAC_BITS");
  end
  if (ACC_WIDTH_BITS < 2 * DATA_WIDTH_BITS || NUM_ACC < 2) begin : g_bad_acc
    $error("ACC_WIDTH_BITS must be >= 2*DATA_WIDTH_BITS and NUM_ACC >= 2");
  end

  logic signed [AW-1:0] bank [NUM_ACC];
  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        drain_sel;

  // ---------------- pass-through ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wgt_out       <= '0;
      wgt_valid_out <= 1'b0;
      act_out       <= '0;
      act_valid_out <= 1'b0;
      acc_bank_out  <= '0;
    end else begin
      wgt_out       <= wgt;
      wgt_valid_out <= wgt_valid;
      act_out       <= act;
      act_valid_out <= act_valid;
      acc_bank_out  <= acc_bank;
    end
  end

  // ---------------- bank read muxes ----------------
  logic signed [AW-1:0] acc_cur, drn_cur;
  logic                 acc_hit, drn_hit;

  always_comb begin
    acc_cur = '0;
    acc_hit = 1'b0;
    drn_cur = '0;
    drn_hit = 1'b0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (acc_bank == BW'(i)) begin
        acc_cur = bank[i];
        acc_hit = 1'b1;
      end
      if (drain_bank == BW'(i)) begin
        drn_cur = bank[i];
        drn_hit = 1'b1;
      end
    end
  end

  // ---------------- multiply-accumulate ----------------
  logic signed [PW-1:0] wgt_ext, act_ext, product;
  logic signed [AW-1:0] prod_ext, acc_next;
  logic signed [AW:0]   sum_wide;
  logic                 ovf_pos, ovf_neg;

  assign wgt_ext  = PW'($signed(wgt));
  assign act_ext  = PW'($signed(act));
  assign product  = wgt_ext * act_ext;
  assign prod_ext = AW'(product);
  // One guard bit above the accumulator reveals signed overflow of the sum.
  assign sum_wide = (AW+1)'(acc_cur) + (AW+1)'(prod_ext);
  assign ovf_pos  = !sum_wide[AW] &&  sum_wide[AW-1];
  assign ovf_neg  =  sum_wide[AW] && !sum_wide[AW-1];

  always_comb begin
    acc_next = sum_wide[AW-1:0];
    if (SATURATE != 0) begin
      if (ovf_pos) acc_next = ACC_MAX;
      else if (ovf_neg) acc_next = ACC_MIN;
    end
  end

  // ---------------- result conversion ----------------
  logic signed [AW:0]  rnd_wide, shifted;
  logic [AW-DW+1:0]    upper;
  logic                conv_fits;
  logic [DW-1:0]       conv_val;

  assign rnd_wide  = (AW+1)'(drn_cur) + RND;
  assign shifted   = rnd_wide >>> FRAC_BITS;
  // The result fits when every bit from the output sign bit upward agrees.
  assign upper     = shifted[AW:DW-1];
  assign conv_fits = (&upper) | ~(|upper);

  always_comb begin
    conv_val = shifted[DW-1:0];
    if (SATURATE != 0 && !conv_fits) conv_val = shifted[AW] ? RES_MIN : RES_MAX;
  end

  // ---------------- control ----------------
  logic compute, start, conflict, do_acc, sat_set;

  assign drain_busy = (state != S_IDLE);
  assign compute    = wgt_valid && act_valid;
  assign start      = (state == S_IDLE) && drain_start;
  // The drained bank is protected for the start cycle and for the whole busy
  // window, so the drained value is always the pre-cycle contents.
  assign conflict   = compute && acc_hit &&
                      ((drain_busy && acc_bank == drain_sel) ||
                       (start && acc_bank == drain_bank));
  assign do_acc     = compute && acc_hit && !conflict;
  assign sat_set    = (SATURATE != 0) &&
                      ((do_acc && (ovf_pos || ovf_neg)) || (start && drn_hit && !conv_fits));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (start && drain_bank == BW'(i)) bank[i] <= '0;
        else if (do_acc && acc_bank == BW'(i)) bank[i] <= acc_next;
      end
    end
  end

  // A set and a clear in the same cycle resolve to set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag      <= 1'b0;
      conflict_flag <= 1'b0;
    end else begin
      if (sat_set) sat_flag <= 1'b1;
      else if (clear_flags) sat_flag <= 1'b0;
      if (conflict) conflict_flag <= 1'b1;
      else if (clear_flags) conflict_flag <= 1'b0;
    end
  end

  // ---------------- drain sequencer ----------------
  // IDLE: emit own converted result on drain_start.
  // PASS: forward neighbour results until DRAIN_PASS valid words have moved.
  // DONE: one cycle with the output invalid, then back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      drain_sel       <= '0;
      drain_out       <= '0;
      drain_out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          drain_out_valid <= 1'b0;
          if (drain_start) begin
            drain_out       <= conv_val;
            drain_out_valid <= 1'b1;
            drain_sel       <= drain_bank;
            cnt             <= CW'(DRAIN_PASS);
            state           <= (DRAIN_PASS == 0) ? S_DONE : S_PASS;
          end
        end
        S_PASS: begin
          drain_out       <= drain_in;
          drain_out_valid <= drain_in_valid;
          if (drain_in_valid) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_DONE;
          end
        end
        S_DONE: begin
          drain_out_valid <= 1'b0;
          state           <= S_IDLE;
        end
        default: begin
          drain_out_valid <= 1'b0;
          state           <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_pe_dual_bank.sv
// tb_systolic_pe_dual_bank
//   Self-checking bench for systolic_pe_dual_bank at default parameters
//   (16-bit Q7.8 operands, 40-bit accumulators, two banks, DRAIN_PASS=3).
module tb_systolic_pe_dual_bank;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] wgt, act, wgt_out, act_out, drain_in, drain_out;
  logic        wgt_valid, act_valid, wgt_valid_out, act_valid_out;
  logic        acc_bank, acc_bank_out, drain_start, drain_bank;
  logic        drain_in_valid, drain_out_valid, drain_busy;
  logic        sat_flag, conflict_flag, clear_flags;

  systolic_pe_dual_bank dut (
    .clk(clk), .rst(rst),
    .wgt(wgt), .wgt_valid(wgt_valid), .act(act), .act_valid(act_valid),
    .acc_bank(acc_bank),
    .wgt_out(wgt_out), .wgt_valid_out(wgt_valid_out),
    .act_out(act_out), .act_valid_out(act_valid_out),
    .acc_bank_out(acc_bank_out),
    .drain_start(drain_start), .drain_bank(drain_bank),
    .drain_in(drain_in), .drain_in_valid(drain_in_valid),
    .drain_out(drain_out), .drain_out_valid(drain_out_valid),
    .drain_busy(drain_busy), .sat_flag(sat_flag),
    .conflict_flag(conflict_flag), .clear_flags(clear_flags)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Banks are plain integers; each MAC is exact arithmetic, then clamped.
  longint model_bank[2];
  bit     model_sat;
  localparam longint ACC_HI = (longint'(1) <<< 39) - 1;
  localparam longint ACC_LO = -(longint'(1) <<< 39);

  function automatic longint mul(input logic [15:0] w, input logic [15:0] a);
    return longint'($signed(w)) * longint'($signed(a));
  endfunction

  task automatic model_mac(input int b, input logic [15:0] w, input logic [15:0] a);
    longint s;
    s = model_bank[b] + mul(w, a);
    if (s > ACC_HI) begin s = ACC_HI; model_sat = 1'b1; end
    else if (s < ACC_LO) begin s = ACC_LO; model_sat = 1'b1; end
    model_bank[b] = s;
  endtask

  // Round half up to the nearest 1/256 step, then clamp to Q7.8.
  function automatic logic [15:0] model_conv(input longint v, output bit clamped);
    longint r;
    r = (v + 128) >>> 8;
    clamped = 1'b0;
    if (r > 32767) begin clamped = 1'b1; return 16'h7FFF; end
    if (r < -32768) begin clamped = 1'b1; return 16'h8000; end
    return 16'(r);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    wgt = '0; act = '0; wgt_valid = 0; act_valid = 0; acc_bank = 0;
    drain_start = 0; drain_bank = 0; drain_in = '0; drain_in_valid = 0;
    clear_flags = 0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1;
    @(negedge clk);
    clear_flags = 0;
  endtask

  task automatic mac(input int b, input logic [15:0] w, input logic [15:0] a, input int n);
    wgt = w; act = a; acc_bank = b[0];
    wgt_valid = 1; act_valid = 1;
    repeat (n) @(negedge clk);
    wgt_valid = 0; act_valid = 0;
  endtask

  // Drain bank b. The neighbour supplies three words with one idle gap.
  // Any compute inputs already driven stay applied for the six clock edges
  // of the drain and are dropped at the end. With spurious set, a second
  // drain_start for the other bank is issued during PASS.
  task automatic do_drain(input int b, input logic [15:0] exp_own, input bit spurious, input string tag);
    logic [15:0] pv[3];
    for (int i = 0; i < 3; i++) pv[i] = 16'($urandom);
    drain_start = 1; drain_bank = b[0];
    @(negedge clk);
    drain_start = 0;
    check({tag, " own value"}, drain_out, exp_own);
    check({tag, " own valid"}, drain_out_valid, 1);
    check({tag, " busy"}, drain_busy, 1);
    drain_in = pv[0]; drain_in_valid = 1;
    @(negedge clk);
    check({tag, " pass0"}, drain_out, pv[0]);
    check({tag, " pass0 valid"}, drain_out_valid, 1);
    drain_in_valid = 0; drain_in = 16'($urandom);
    if (spurious) begin drain_start = 1; drain_bank = ~b[0]; end
    @(negedge clk);
    drain_start = 0;
    check({tag, " gap valid"}, drain_out_valid, 0);
    check({tag, " gap busy"}, drain_busy, 1);
    drain_in = pv[1]; drain_in_valid = 1;
    @(negedge clk);
    check({tag, " pass1"}, drain_out, pv[1]);
    check({tag, " pass1 valid"}, drain_out_valid, 1);
    drain_in = pv[2];
    @(negedge clk);
    check({tag, " pass2"}, drain_out, pv[2]);
    check({tag, " pass2 valid"}, drain_out_valid, 1);
    check({tag, " busy in done"}, drain_busy, 1);
    drain_in_valid = 0;
    @(negedge clk);
    check({tag, " done valid"}, drain_out_valid, 0);
    check({tag, " idle busy"}, drain_busy, 0);
    wgt_valid = 0; act_valid = 0;
  endtask

  // Drain a bank using the model value and clear the model bank.
  task automatic model_drain(input int b, input string tag);
    bit c;
    logic [15:0] e;
    e = model_conv(model_bank[b], c);
    if (c) model_sat = 1'b1;
    model_bank[b] = 0;
    do_drain(b, e, 0, tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0] w;
    logic [15:0] a;
    int          n;
    logic [15:0] exp;
    logic        exp_sat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    idle_inputs();
    rst = 1;
    model_bank[0] = 0; model_bank[1] = 0; model_sat = 0;

    tbl[0]  = '{16'h0180, 16'h0200, 1, 16'h0300, 1'b0}; // 1.5*2.0
    tbl[1]  = '{16'h0180, 16'h0200, 0, 16'h0000, 1'b0}; // bank empty after drain
    tbl[2]  = '{16'hFE80, 16'h0100, 4, 16'hFA00, 1'b0}; // 4 * -1.5
    tbl[3]  = '{16'h6400, 16'h6400, 1, 16'h7FFF, 1'b1}; // 100*100 clamps high
    tbl[4]  = '{16'h9C00, 16'h6400, 1, 16'h8000, 1'b1}; // -100*100 clamps low
    tbl[5]  = '{16'h0001, 16'h0080, 1, 16'h0001, 1'b0}; // exactly half rounds up
    tbl[6]  = '{16'h0001, 16'h007F, 1, 16'h0000, 1'b0}; // just below half
    tbl[7]  = '{16'hFFFF, 16'h0080, 1, 16'h0000, 1'b0}; // -half rounds up to 0
    tbl[8]  = '{16'hFFFF, 16'h0081, 1, 16'hFFFF, 1'b0}; // just past -half
    tbl[9]  = '{16'h0100, 16'h0100, 3, 16'h0300, 1'b0}; // 3 * 1.0
    tbl[10] = '{16'h7FFF, 16'h0100, 1, 16'h7FFF, 1'b0}; // largest in range
    tbl[11] = '{16'h8000, 16'h0100, 1, 16'h8000, 1'b0}; // smallest in range

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst wgt_out", wgt_out, 0);
    check("rst valid outs", {wgt_valid_out, act_valid_out, acc_bank_out}, 0);
    check("rst act_out", act_out, 0);
    check("rst drain_out", drain_out, 0);
    check("rst drain_out_valid", drain_out_valid, 0);
    check("rst busy", drain_busy, 0);
    check("rst flags", {sat_flag, conflict_flag}, 0);
    rst = 0;
    @(negedge clk);

    // ---- table: MACs on bank0, drain bank0 ----
    for (int i = 0; i < 12; i++) begin
      pulse_clear();
      mac(0, tbl[i].w, tbl[i].a, tbl[i].n);
      do_drain(0, tbl[i].exp, 0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d sat_flag", i), sat_flag, tbl[i].exp_sat);
      check($sformatf("vec%0d conflict_flag", i), conflict_flag, 0);
    end

    // ---- accumulator saturation: 520 * 2^30 exceeds 2^39-1 ----
    pulse_clear();
    check("flags cleared", {sat_flag, conflict_flag}, 0);
    mac(1, 16'h8000, 16'h8000, 520);
    @(negedge clk);
    check("acc sat flag", sat_flag, 1);
    do_drain(1, 16'h7FFF, 0, "acc sat drain");

    // ---- conflict on drained bank, with a spurious start during PASS ----
    pulse_clear();
    mac(0, 16'h0100, 16'h0100, 1);
    mac(1, 16'h0300, 16'h0100, 1);
    wgt = 16'h0200; act = 16'h0100; acc_bank = 0; wgt_valid = 1; act_valid = 1;
    do_drain(0, 16'h0100, 1, "conflict");
    check("conflict flag set", conflict_flag, 1);
    pulse_clear();
    check("conflict flag cleared", conflict_flag, 0);
    do_drain(0, 16'h0000, 0, "conflict bank0 empty");
    do_drain(1, 16'h0300, 0, "bank1 kept");
    check("no conflict after", conflict_flag, 0);

    // ---- ping-pong: bank1 accumulates on all six edges of a bank0 drain ----
    mac(0, 16'h0200, 16'h0100, 1);
    wgt = 16'h0100; act = 16'h0100; acc_bank = 1; wgt_valid = 1; act_valid = 1;
    do_drain(0, 16'h0200, 0, "pingpong bank0");
    do_drain(1, 16'h0600, 0, "pingpong bank1");
    check("pingpong conflict", conflict_flag, 0);

    // ---- randomized rounds against the model ----
    for (int r = 0; r < 3; r++) begin
      pulse_clear();
      model_sat = 0;
      for (int k = 0; k < 150; k++) begin
        logic [15:0] w, a;
        logic wv, av, b;
        if (r == 0) begin w = 16'($urandom); a = 16'($urandom); end
        else begin
          w = 16'($urandom_range(0, 1023)) - 16'd512;
          a = 16'($urandom_range(0, 1023)) - 16'd512;
        end
        wv = ($urandom_range(0, 3) != 0);
        av = ($urandom_range(0, 3) != 0);
        b  = 1'($urandom_range(0, 1));
        wgt = w; act = a; wgt_valid = wv; act_valid = av; acc_bank = b;
        if (wv && av) model_mac(int'(b), w, a);
        @(negedge clk);
        check("pt wgt", wgt_out, w);
        check("pt act", act_out, a);
        check("pt valids", {wgt_valid_out, act_valid_out, acc_bank_out}, {wv, av, b});
      end
      wgt_valid = 0; act_valid = 0;
      model_drain(0, $sformatf("rand%0d bank0", r));
      model_drain(1, $sformatf("rand%0d bank1", r));
      check($sformatf("rand%0d sat_flag", r), sat_flag, model_sat);
    end

    // ---- reset in the middle of a drain ----
    mac(0, 16'h0100, 16'h0100, 2);
    mac(1, 16'h0500, 16'h0100, 1);
    drain_start = 1; drain_bank = 0;
    @(negedge clk);
    drain_start = 0; drain_in = 16'h1234; drain_in_valid = 1;
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("rst mid valid", drain_out_valid, 0);
    check("rst mid busy", drain_busy, 0);
    check("rst mid drain_out", drain_out, 0);
    drain_in_valid = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    do_drain(0, 16'h0000, 0, "post rst bank0");
    do_drain(1, 16'h0000, 0, "post rst bank1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
